// File: rtl/cr_stat_accum_array_if.sv
// Bundles the event, config, snapshot/clear and read-port signals of
// cr_stat_accum_array.
//   master : the side that drives events, config and read requests
//   slave  : the statistics block itself
// Read handshake: rd_req is a single-cycle request with no ready/backpressure.
// Every cycle with rd_req=1 produces exactly one rd_vld=1 cycle on the next
// cycle, and rd_data/rd_ovf are valid only while rd_vld=1. Requests may be
// issued every cycle.
interface cr_stat_accum_array_if #(
  parameter int N_EVENTS = 64,
  parameter int N_CNTRS  = 16,
  parameter int CNT_W    = 50,
  parameter int SEL_W    = $clog2(N_EVENTS),
  parameter int IDX_W    = $clog2(N_CNTRS)
);
  logic [N_EVENTS-1:0] stat_events;
  logic                cfg_wr;
  logic [IDX_W-1:0]    cfg_idx;
  logic [SEL_W-1:0]    cfg_sel;
  logic                cfg_en;
  logic                cfg_sat;
  logic                snap_req;
  logic                clr_on_snap;
  logic                clr_live;
  logic                rd_req;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_live;
  logic                rd_vld;
  logic [CNT_W-1:0]    rd_data;
  logic                rd_ovf;
  logic                ovf_any;

  modport master (
    output stat_events, cfg_wr, cfg_idx, cfg_sel, cfg_en, cfg_sat,
           snap_req, clr_on_snap, clr_live, rd_req, rd_idx, rd_live,
    input  rd_vld, rd_data, rd_ovf, ovf_any
  );

  modport slave (
    input  stat_events, cfg_wr, cfg_idx, cfg_sel, cfg_en, cfg_sat,
           snap_req, clr_on_snap, clr_live, rd_req, rd_idx, rd_live,
    output rd_vld, rd_data, rd_ovf, ovf_any
  );
endinterface

// File: rtl/cr_stat_accum_array.sv
// Statistics aggregator: N_CNTRS live counters, each fed by one configurable
// bit of the stat_events bus, with per-counter enable and saturate/wrap mode,
// sticky overflow flags, an atomic snapshot bank (optional clear-on-snap) and
// a registered read port.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high; clears all state
//   bus  : cr_stat_accum_array_if.slave (events, config, snapshot, clear,
//          read request and read response, ovf_any)
// Requires N_CNTRS >= 2 and N_EVENTS >= 2 so the index fields are non-empty.
module cr_stat_accum_array #(
  parameter int N_EVENTS = 64,
  parameter int N_CNTRS  = 16,
  parameter int CNT_W    = 50,
  parameter int SEL_W    = $clog2(N_EVENTS),
  parameter int IDX_W    = $clog2(N_CNTRS)
) (
  input  logic                   clk,
  input  logic                   rst,
  cr_stat_accum_array_if.slave   bus
);

  logic [N_EVENTS-1:0] ev_q;

  logic [CNT_W-1:0]    live_q   [N_CNTRS];
  logic [CNT_W-1:0]    live_d   [N_CNTRS];
  logic [CNT_W-1:0]    snap_q   [N_CNTRS];
  logic [SEL_W-1:0]    sel_q    [N_CNTRS];
  logic [N_CNTRS-1:0]  ovf_q;
  logic [N_CNTRS-1:0]  ovf_d;
  logic [N_CNTRS-1:0]  snap_ovf_q;
  logic [N_CNTRS-1:0]  en_q;
  logic [N_CNTRS-1:0]  sat_q;
  logic [N_CNTRS-1:0]  inc;

  logic                rd_vld_q;
  logic [CNT_W-1:0]    rd_data_q;
  logic                rd_ovf_q;
  logic                ovf_any_q;

  logic                snap_clr;
  logic                cfg_idx_ok;
  logic                rd_idx_ok;

  // With clr_on_snap the live side restarts from zero in the snapshot cycle,
  // and that cycle's increment is applied on top of the zero.
  assign snap_clr   = bus.snap_req & bus.clr_on_snap;
  assign cfg_idx_ok = {1'b0, bus.cfg_idx} < (IDX_W + 1)'(N_CNTRS);
  assign rd_idx_ok  = {1'b0, bus.rd_idx}  < (IDX_W + 1)'(N_CNTRS);

  // Next live value / overflow flag per counter.
  always_comb begin
    inc = '0;
    for (int i = 0; i < N_CNTRS; i++) begin
      live_d[i] = live_q[i];
      ovf_d[i]  = ovf_q[i];
      // Out-of-range selects (non power-of-two N_EVENTS) never count.
      if ({1'b0, sel_q[i]} < (SEL_W + 1)'(N_EVENTS)) begin
        inc[i] = en_q[i] & ev_q[sel_q[i]];
      end
      if (snap_clr) begin
        live_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end
      if (bus.clr_live) begin
        // Clear wins over increment: the event of this cycle is dropped.
        live_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end else if (inc[i]) begin
        if (&live_d[i]) begin
          ovf_d[i] = 1'b1;
          if (!sat_q[i]) begin
            live_d[i] = '0;
          end
        end else begin
          live_d[i] = live_d[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event stage, live counters, snapshot bank and config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_q       <= '0;
      ovf_q      <= '0;
      snap_ovf_q <= '0;
      en_q       <= '0;
      sat_q      <= '0;
      for (int i = 0; i < N_CNTRS; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else begin
      ev_q  <= bus.stat_events;
      ovf_q <= ovf_d;
      for (int i = 0; i < N_CNTRS; i++) begin
        live_q[i] <= live_d[i];
      end
      // Snapshot takes the pre-increment, pre-clear live state of every
      // counter in the same edge, so the bank is mutually consistent.
      if (bus.snap_req) begin
        snap_ovf_q <= ovf_q;
        for (int i = 0; i < N_CNTRS; i++) begin
          snap_q[i] <= live_q[i];
        end
      end
      // New config is seen by the increment logic from the next cycle on.
      if (bus.cfg_wr && cfg_idx_ok) begin
        sel_q[bus.cfg_idx] <= bus.cfg_sel;
        en_q[bus.cfg_idx]  <= bus.cfg_en;
        sat_q[bus.cfg_idx] <= bus.cfg_sat;
      end
    end
  end

  // Read port and overflow summary. Reads sample register state before the
  // current edge updates it, so a snapshot read in the snap_req cycle returns
  // the previous snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
      ovf_any_q <= 1'b0;
    end else begin
      rd_vld_q  <= bus.rd_req;
      ovf_any_q <= |ovf_q;
      if (bus.rd_req) begin
        if (!rd_idx_ok) begin
          rd_data_q <= '0;
          rd_ovf_q  <= 1'b0;
        end else if (bus.rd_live) begin
          rd_data_q <= live_q[bus.rd_idx];
          rd_ovf_q  <= ovf_q[bus.rd_idx];
        end else begin
          rd_data_q <= snap_q[bus.rd_idx];
          rd_ovf_q  <= snap_ovf_q[bus.rd_idx];
        end
      end
    end
  end

  assign bus.rd_vld  = rd_vld_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_ovf  = rd_ovf_q;
  assign bus.ovf_any = ovf_any_q;

endmodule
